// File: rtl/tile_timer_irq_gen.sv
// Per-tile machine timer (mtime/mtimecmp) and software interrupt (msip) behind a
// single-outstanding register port. Optional macro TILE_TIMER_RTC_SYNC_EN adds an rtc_i synchronizer.
module tile_timer_irq_gen #(
   parameter int unsigned AddrWidth = 16,
   parameter int unsigned TimeIncr  = 1
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 rtc_i,
   input  logic                 req_valid_i,
   output logic                 req_ready_o,
   input  logic                 req_we_i,
   input  logic [AddrWidth-1:0] req_addr_i,
   input  logic [7:0]           req_be_i,
   input  logic [63:0]          req_wdata_i,
   output logic                 rsp_valid_o,
   input  logic                 rsp_ready_i,
   output logic [63:0]          rsp_rdata_o,
   output logic                 rsp_err_o,
   output logic                 time_irq_o,
   output logic                 ipi_o
);

   typedef enum logic {IDLE = 1'b0, RESP = 1'b1} state_e;

   state_e      state_q, state_d;
   logic [63:0] mtime_q, mtime_d;
   logic [63:0] mtimecmp_q, mtimecmp_d;
   logic        msip_q, msip_d;
   logic        irq_q, irq_d;
   logic [63:0] rsp_rdata_q, rsp_rdata_d;
   logic        rsp_err_q, rsp_err_d;
   logic        rtc_s, rtc_prev_q, tick;

   // ---------------- rtc edge detection ----------------
`ifdef TILE_TIMER_RTC_SYNC_EN
   logic [1:0] rtc_sync_q;
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rtc_sync_q <= 2'b00;
         rtc_prev_q <= 1'b0;
      end else begin
         rtc_sync_q <= {rtc_sync_q[0], rtc_i};
         rtc_prev_q <= rtc_sync_q[1];
      end
   end
   assign rtc_s = rtc_sync_q[1];
`else
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) rtc_prev_q <= 1'b0;
      else         rtc_prev_q <= rtc_i;
   end
   assign rtc_s = rtc_i;
`endif

   assign tick = rtc_s & ~rtc_prev_q;

   // ---------------- address decode ----------------
   logic       hi_err, unmapped, acc, unused_addr;
   logic [1:0] sel;

   if (AddrWidth > 5) begin : g_hi
      assign hi_err = |req_addr_i[AddrWidth-1:5];
   end else begin : g_nohi
      assign hi_err = 1'b0;
   end

   assign sel         = req_addr_i[4:3];
   assign unmapped    = hi_err | (sel == 2'd3);
   assign acc         = (state_q == IDLE) & req_valid_i;
   assign unused_addr = ^req_addr_i[2:0];

   // ---------------- register file next state ----------------
   logic [63:0] rmux;

   always_comb begin
      mtime_d    = tick ? (mtime_q + 64'(TimeIncr)) : mtime_q;
      mtimecmp_d = mtimecmp_q;
      msip_d     = msip_q;
      // Written mtime bytes override the tick; unwritten ones keep the ticked value.
      if (acc && req_we_i && !unmapped) begin
         case (sel)
            2'd0: if (req_be_i[0]) msip_d = req_wdata_i[0];
            2'd1: for (int b = 0; b < 8; b++)
                     if (req_be_i[b]) mtimecmp_d[8*b +: 8] = req_wdata_i[8*b +: 8];
            2'd2: for (int b = 0; b < 8; b++)
                     if (req_be_i[b]) mtime_d[8*b +: 8] = req_wdata_i[8*b +: 8];
            default: ;
         endcase
      end
      irq_d = (mtime_d >= mtimecmp_d);
   end

   always_comb begin
      rmux = 64'd0;
      case (sel)
         2'd0:    rmux = {63'd0, msip_q};
         2'd1:    rmux = mtimecmp_q;
         2'd2:    rmux = mtime_q;
         default: rmux = 64'd0;
      endcase
      if (unmapped) rmux = 64'd0;
   end

   always_comb begin
      rsp_rdata_d = rsp_rdata_q;
      rsp_err_d   = rsp_err_q;
      if (acc) begin
         rsp_rdata_d = req_we_i ? 64'd0 : rmux;
         rsp_err_d   = unmapped;
      end else if (state_q == RESP && rsp_ready_i) begin
         rsp_rdata_d = 64'd0;
         rsp_err_d   = 1'b0;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         mtime_q     <= 64'd0;
         mtimecmp_q  <= '1;
         msip_q      <= 1'b0;
         irq_q       <= 1'b0;
         rsp_rdata_q <= 64'd0;
         rsp_err_q   <= 1'b0;
      end else begin
         mtime_q     <= mtime_d;
         mtimecmp_q  <= mtimecmp_d;
         msip_q      <= msip_d;
         irq_q       <= irq_d;
         rsp_rdata_q <= rsp_rdata_d;
         rsp_err_q   <= rsp_err_d;
      end
   end

   // ---------------- port FSM ----------------
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) state_q <= IDLE;
      else         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (req_valid_i) state_d = RESP;
         RESP:    if (rsp_ready_i) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      req_ready_o = (state_q == IDLE);
      rsp_valid_o = (state_q == RESP);
   end

   assign rsp_rdata_o = rsp_rdata_q;
   assign rsp_err_o   = rsp_err_q;
   assign time_irq_o  = irq_q;
   assign ipi_o       = msip_q;

endmodule

// File: tb/tb_tile_timer_irq_gen.sv
// Directed + randomized bench for tile_timer_irq_gen against a plain arithmetic model.
module tb_tile_timer_irq_gen;
   localparam int unsigned AW   = 16;
   localparam int unsigned INCR = 1;
`ifdef TILE_TIMER_RTC_SYNC_EN
   localparam int TICK_LAT = 3;
`else
   localparam int TICK_LAT = 1;
`endif

   logic          clk = 1'b0, rst_n = 1'b0, rtc = 1'b0;
   logic          req_valid = 1'b0, req_ready, req_we = 1'b0;
   logic [AW-1:0] req_addr = '0;
   logic [7:0]    req_be = 8'h00;
   logic [63:0]   req_wdata = 64'd0;
   logic          rsp_valid, rsp_ready = 1'b0, rsp_err, time_irq, ipi;
   logic [63:0]   rsp_rdata;

   int nchk = 0, nerr = 0;

   // reference model state
   logic [63:0] m_time, m_cmp;
   logic        m_msip;

   tile_timer_irq_gen #(.AddrWidth(AW), .TimeIncr(INCR)) dut (
      .clk_i(clk), .rst_ni(rst_n), .rtc_i(rtc),
      .req_valid_i(req_valid), .req_ready_o(req_ready), .req_we_i(req_we),
      .req_addr_i(req_addr), .req_be_i(req_be), .req_wdata_i(req_wdata),
      .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_rdata_o(rsp_rdata),
      .rsp_err_o(rsp_err), .time_irq_o(time_irq), .ipi_o(ipi));

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      nchk++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [63:0] bmask(input logic [63:0] old, input logic [63:0] nw,
                                         input logic [7:0] be);
      logic [63:0] r;
      r = old;
      for (int b = 0; b < 8; b++) if (be[b]) r[8*b +: 8] = nw[8*b +: 8];
      return r;
   endfunction

   task automatic model_reset();
      m_time = 64'd0; m_cmp = '1; m_msip = 1'b0;
   endtask

   task automatic chk_irq(input string tag);
      chk({tag, ".irq"}, {63'd0, time_irq}, {63'd0, (m_time >= m_cmp)});
      chk({tag, ".ipi"}, {63'd0, ipi}, {63'd0, m_msip});
   endtask

   // Caller sits just after a rising edge. rtc pulse long enough for either build.
   task automatic do_tick();
      rtc = 1'b1;
      repeat (3) @(posedge clk);
      #1 rtc = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      m_time = m_time + 64'(INCR);
   endtask

   // One complete access; with_tick lines a tick up with the accepting edge.
   task automatic xfer(input string tag, input logic we, input logic [AW-1:0] addr,
                       input logic [7:0] be, input logic [63:0] wd, input bit with_tick);
      logic [63:0] exp_rd;
      logic        exp_err;
      logic [1:0]  sel;
      sel     = addr[4:3];
      exp_err = (addr[AW-1:5] != '0) || (sel == 2'd3);
      exp_rd  = 64'd0;
      if (!we && !exp_err)
         exp_rd = (sel == 2'd0) ? {63'd0, m_msip} : (sel == 2'd1) ? m_cmp : m_time;
      if (with_tick) begin
         rtc = 1'b1;
         if (TICK_LAT > 1) begin
            repeat (TICK_LAT - 1) @(posedge clk);
            #1;
         end
         m_time = m_time + 64'(INCR);
      end
      if (we && !exp_err) begin
         case (sel)
            2'd0: if (be[0]) m_msip = wd[0];
            2'd1: m_cmp  = bmask(m_cmp, wd, be);
            2'd2: m_time = bmask(m_time, wd, be);
            default: ;
         endcase
      end
      req_valid = 1'b1; req_we = we; req_addr = addr; req_be = be; req_wdata = wd;
      chk({tag, ".req_ready"}, {63'd0, req_ready}, 64'd1);
      @(posedge clk);
      #1 req_valid = 1'b0;
      chk({tag, ".rsp_valid"}, {63'd0, rsp_valid}, 64'd1);
      chk({tag, ".rdata"}, rsp_rdata, exp_rd);
      chk({tag, ".err"}, {63'd0, rsp_err}, {63'd0, exp_err});
      chk_irq(tag);
      rsp_ready = 1'b1;
      @(posedge clk);
      #1 rsp_ready = 1'b0;
      chk({tag, ".rsp_done"}, {62'd0, rsp_valid, rsp_err}, 64'd0);
      if (with_tick) begin
         rtc = 1'b0;
         repeat (3) @(posedge clk);
         #1;
      end
   endtask

   logic [AW-1:0] addr_tbl [6];

   initial begin
      addr_tbl[0] = 16'h0000; addr_tbl[1] = 16'h0008; addr_tbl[2] = 16'h0010;
      addr_tbl[3] = 16'h0018; addr_tbl[4] = 16'h0020; addr_tbl[5] = 16'h0108;
      model_reset();

      // reset state
      #2;
      chk("rst.req_ready", {63'd0, req_ready}, 64'd1);
      chk("rst.rsp", {rsp_rdata[61:0], rsp_valid, rsp_err}, 64'd0);
      chk_irq("rst");
      @(posedge clk); #1 rst_n = 1'b1;
      @(posedge clk); #1;
      xfer("rd_mtime", 1'b0, 16'h0010, 8'h00, 64'd0, 1'b0);
      xfer("rd_cmp",   1'b0, 16'h0008, 8'h00, 64'd0, 1'b0);
      xfer("rd_msip",  1'b0, 16'h0000, 8'h00, 64'd0, 1'b0);

      // compare threshold: 5 ticks, exact timing on the 5th
      xfer("wr_cmp5", 1'b1, 16'h0008, 8'hFF, 64'd5, 1'b0);
      repeat (4) do_tick();
      chk_irq("tick4");
      rtc = 1'b1;
      repeat (TICK_LAT - 1) @(posedge clk);
      #1 chk("tick5.pre", {63'd0, time_irq}, 64'd0);
      @(posedge clk);
      #1 chk("tick5.post", {63'd0, time_irq}, 64'd1);
      repeat (2) @(posedge clk);
      #1 rtc = 1'b0;
      repeat (3) @(posedge clk);
      #1 m_time = m_time + 64'(INCR);
      xfer("rd_mtime5", 1'b0, 16'h0010, 8'h00, 64'd0, 1'b0);
      xfer("wr_cmp100", 1'b1, 16'h0008, 8'hFF, 64'd100, 1'b0);

      // msip
      xfer("msip1",   1'b1, 16'h0000, 8'h01, 64'd1, 1'b0);
      xfer("msip0",   1'b1, 16'h0000, 8'h01, 64'd0, 1'b0);
      xfer("msip_be", 1'b1, 16'h0000, 8'h00, 64'd1, 1'b0);

      // wrap
      xfer("wr_mtime_fe", 1'b1, 16'h0010, 8'hFF, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0);
      xfer("wr_cmp_ff",   1'b1, 16'h0008, 8'hFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
      do_tick();
      chk("wrap.irq_hi", {63'd0, time_irq}, 64'd1);
      do_tick();
      chk("wrap.irq_lo", {63'd0, time_irq}, 64'd0);
      xfer("rd_wrap", 1'b0, 16'h0010, 8'h00, 64'd0, 1'b0);
      chk("wrap.model", m_time, 64'd0);

      // write/tick collision
      xfer("wr_mtime_c", 1'b1, 16'h0010, 8'hFF, 64'h1_0000_0003, 1'b0);
      xfer("collide",    1'b1, 16'h0010, 8'h0F, 64'd0, 1'b1);
      xfer("rd_collide", 1'b0, 16'h0010, 8'h00, 64'd0, 1'b0);
      chk("collide.model", m_time, 64'h1_0000_0000);

      // unmapped accesses, response held for 4 cycles
      xfer("rd_0x20", 1'b0, 16'h0020, 8'h00, 64'd0, 1'b0);
      req_valid = 1'b1; req_we = 1'b0; req_addr = 16'h0018;
      @(posedge clk);
      #1 req_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("hold%0d.valid_ready", i), {62'd0, rsp_valid, req_ready}, 64'd2);
         chk($sformatf("hold%0d.data", i), rsp_rdata, 64'd0);
         chk($sformatf("hold%0d.err", i), {63'd0, rsp_err}, 64'd1);
         @(posedge clk); #1;
      end
      rsp_ready = 1'b1;
      @(posedge clk);
      #1 rsp_ready = 1'b0;
      chk("hold.done", {62'd0, rsp_valid, rsp_err}, 64'd0);

      // randomized traffic
      for (int n = 0; n < 40; n++) begin
         logic [AW-1:0] a;
         a = addr_tbl[$urandom_range(0, 5)] | AW'($urandom_range(0, 7));
         if ($urandom_range(0, 4) == 0) do_tick();
         xfer($sformatf("rnd%0d", n), 1'($urandom), a, 8'($urandom),
              {$urandom, $urandom}, 1'b0);
      end

      // reset in the middle of a response
      xfer("pre_rst", 1'b1, 16'h0000, 8'h01, 64'd1, 1'b0);
      req_valid = 1'b1; req_we = 1'b0; req_addr = 16'h0008;
      @(posedge clk);
      #1 req_valid = 1'b0;
      rst_n = 1'b0;
      #1;
      model_reset();
      chk("midrst.valid_ready", {62'd0, rsp_valid, req_ready}, 64'd1);
      chk("midrst.rdata", rsp_rdata, 64'd0);
      chk_irq("midrst");
      @(posedge clk); #1 rst_n = 1'b1;
      @(posedge clk); #1;
      xfer("post_rst_mtime", 1'b0, 16'h0010, 8'h00, 64'd0, 1'b0);
      xfer("post_rst_cmp",   1'b0, 16'h0008, 8'h00, 64'd0, 1'b0);

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end
endmodule
